// File: rtl/muldiv_seq_ctrl_pkg.sv
// Shared definitions for the sequential multiply/divide controller:
// state encoding, opcode values and the default operand width.
package muldiv_seq_ctrl_pkg;

  localparam int WIDTH_DEF = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam logic OP_MUL = 1'b0;
  localparam logic OP_DIV = 1'b1;

endpackage

// File: rtl/muldiv_seq_ctrl.sv
// Multi-cycle 8x8 unsigned multiply / 8/8 unsigned restoring divide sequencer
// driving an external shared add/sub datapath, one step per clock.
//
// Handshakes: a transfer happens on a rising edge where valid && ready are both
// high; valid and its payload must stay stable until that edge, and ready may
// depend on nothing but controller state (never combinationally on valid).
module muldiv_seq_ctrl
  import muldiv_seq_ctrl_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_opcode,
  input  logic [WIDTH-1:0] in_x,
  input  logic [WIDTH-1:0] in_y,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_hi,
  output logic [WIDTH-1:0] out_lo,
  output logic             out_dz,
  output logic             busy,
  output logic [WIDTH-1:0] add_a,
  output logic [WIDTH-1:0] add_b,
  output logic             add_op,
  input  logic [WIDTH-1:0] add_s,
  input  logic             add_cout
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             op_q, op_d;
  logic             dz_q, dz_d;

  logic             accept;
  logic [WIDTH-1:0] rem_shift;
  logic             mul_c;
  logic [WIDTH-1:0] mul_h;

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign busy      = (state_q != ST_IDLE);
  assign out_hi    = hi_q;
  assign out_lo    = lo_q;
  assign out_dz    = dz_q;
  assign accept    = in_valid && in_ready;

  // Partial remainder shifted left by one with the next dividend bit brought in;
  // hi_q's top bit is provably zero here so nothing is lost.
  assign rem_shift = {hi_q[WIDTH-2:0], lo_q[WIDTH-1]};

  // Multiply step: add the multiplicand only when the current multiplier bit is set.
  assign mul_c = lo_q[0] ? add_cout : 1'b0;
  assign mul_h = lo_q[0] ? add_s    : hi_q;

  always_comb begin
    add_a  = '0;
    add_b  = '0;
    add_op = 1'b0;
    if (state_q == ST_RUN) begin
      add_b = mcand_q;
      if (op_q == OP_MUL) begin
        add_a = hi_q;
      end else begin
        add_a  = rem_shift;
        add_op = 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    mcand_d = mcand_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    dz_d    = dz_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          op_d  = in_opcode;
          cnt_d = '0;
          if (in_opcode == OP_MUL) begin
            hi_d    = '0;
            lo_d    = in_y;
            mcand_d = in_x;
            state_d = ST_RUN;
          end else if (in_y != '0) begin
            hi_d    = '0;
            lo_d    = in_x;
            mcand_d = in_y;
            state_d = ST_RUN;
          end else begin
            // Divide by zero finishes immediately with an all-ones quotient.
            hi_d    = in_x;
            lo_d    = '1;
            dz_d    = 1'b1;
            state_d = ST_DONE;
          end
        end
      end
      ST_RUN: begin
        if (op_q == OP_MUL) begin
          hi_d = {mul_c, mul_h[WIDTH-1:1]};
          lo_d = {mul_h[0], lo_q[WIDTH-1:1]};
        end else if (add_cout) begin
          hi_d = add_s;
          lo_d = {lo_q[WIDTH-2:0], 1'b1};
        end else begin
          hi_d = rem_shift;
          lo_d = {lo_q[WIDTH-2:0], 1'b0};
        end
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST_STEP) begin
          dz_d    = 1'b0;
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      hi_q    <= '0;
      lo_q    <= '0;
      mcand_q <= '0;
      cnt_q   <= '0;
      op_q    <= OP_MUL;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      mcand_q <= mcand_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      dz_q    <= dz_d;
    end
  end

endmodule

// File: tb/tb_muldiv_seq_ctrl.sv
// Directed bench for muldiv_seq_ctrl with a behavioural 8-bit add/sub adder
// on the add_* interface and hand-computed expected results.
module tb_muldiv_seq_ctrl;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic       in_opcode;
  logic [7:0] in_x;
  logic [7:0] in_y;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_hi;
  logic [7:0] out_lo;
  logic       out_dz;
  logic       busy;
  logic [7:0] add_a;
  logic [7:0] add_b;
  logic       add_op;
  logic [7:0] add_s;
  logic       add_cout;

  int total = 0;
  int bad   = 0;

  muldiv_seq_ctrl #(.WIDTH(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_opcode (in_opcode),
    .in_x      (in_x),
    .in_y      (in_y),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_hi    (out_hi),
    .out_lo    (out_lo),
    .out_dz    (out_dz),
    .busy      (busy),
    .add_a     (add_a),
    .add_b     (add_b),
    .add_op    (add_op),
    .add_s     (add_s),
    .add_cout  (add_cout)
  );

  // Shared add/sub datapath: subtract is A + ~B + 1, cout=1 means no borrow.
  logic [8:0] add_full;
  assign add_full = {1'b0, add_a} + {1'b0, (add_op ? ~add_b : add_b)} + {8'd0, add_op};
  assign add_s    = add_full[7:0];
  assign add_cout = add_full[8];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Issues one request and follows it to DONE; expected latency is counted in
  // rising edges after the acceptance edge (0 means DONE right after acceptance).
  task automatic run_op(input string tag, input logic op, input logic [7:0] x,
                        input logic [7:0] y, input int exp_lat,
                        input logic [7:0] eh, input logic [7:0] el,
                        input logic edz, input logic hold);
    int wait_cyc;
    int lat;
    wait_cyc = 0;
    while (!in_ready && wait_cyc < 20) begin
      @(posedge clk); #1;
      wait_cyc++;
    end
    chk({tag, "_ready_before"}, {15'd0, in_ready}, 16'd1);
    in_valid  = 1'b1;
    in_opcode = op;
    in_x      = x;
    in_y      = y;
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_x     = $urandom_range(0, 255);
    in_y     = $urandom_range(0, 255);
    lat = 0;
    while (!out_valid && lat < 20) begin
      chk({tag, "_run_in_ready"}, {15'd0, in_ready}, 16'd0);
      chk({tag, "_run_add_op"}, {15'd0, add_op}, {15'd0, op});
      @(posedge clk); #1;
      lat++;
    end
    chk({tag, "_latency"}, 16'(lat), 16'(exp_lat));
    chk({tag, "_out_valid"}, {15'd0, out_valid}, 16'd1);
    chk({tag, "_result"}, {out_hi, out_lo}, {eh, el});
    chk({tag, "_dz"}, {15'd0, out_dz}, {15'd0, edz});
    if (!hold) begin
      @(posedge clk); #1;
      chk({tag, "_back_idle"}, {14'd0, busy, in_ready}, 16'h0001);
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_opcode = 1'b0;
    in_x      = 8'h00;
    in_y      = 8'h00;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_flags", {12'd0, busy, out_valid, out_dz, in_ready}, 16'h0001);
    chk("rst_adder", {add_a, add_b}, 16'h0000);
    chk("rst_add_op", {15'd0, add_op}, 16'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    run_op("mul_13x11", 1'b0, 8'd13, 8'd11, 8, 8'h00, 8'h8F, 1'b0, 1'b0);
    run_op("mul_ffxff", 1'b0, 8'hFF, 8'hFF, 8, 8'hFE, 8'h01, 1'b0, 1'b0);
    run_op("mul_00xa5", 1'b0, 8'h00, 8'hA5, 8, 8'h00, 8'h00, 1'b0, 1'b0);
    run_op("div_200_7", 1'b1, 8'd200, 8'd7, 8, 8'd4, 8'd28, 1'b0, 1'b0);
    run_op("div_255_1", 1'b1, 8'd255, 8'd1, 8, 8'd0, 8'd255, 1'b0, 1'b0);
    run_op("div_5_9", 1'b1, 8'd5, 8'd9, 8, 8'd5, 8'd0, 1'b0, 1'b0);
    run_op("div_42_0", 1'b1, 8'h42, 8'h00, 0, 8'h42, 8'hFF, 1'b1, 1'b0);
    run_op("mul_3x4", 1'b0, 8'd3, 8'd4, 8, 8'h00, 8'h0C, 1'b0, 1'b0);

    // Backpressure: hold the result while a new request is pending.
    out_ready = 1'b0;
    run_op("bp_mul", 1'b0, 8'h12, 8'h10, 8, 8'h01, 8'h20, 1'b0, 1'b1);
    in_valid  = 1'b1;
    in_opcode = 1'b1;
    in_x      = 8'h77;
    in_y      = 8'h03;
    repeat (5) begin
      @(posedge clk); #1;
      chk("bp_hold_valid", {14'd0, out_valid, in_ready}, 16'h0002);
      chk("bp_hold_data", {out_hi, out_lo}, 16'h0120);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_release_idle", {13'd0, busy, out_valid, in_ready}, 16'h0001);
    run_op("bp_next_div", 1'b1, 8'd100, 8'd10, 8, 8'd0, 8'd10, 1'b0, 1'b0);

    // Reset in the middle of a multiply.
    in_valid  = 1'b1;
    in_opcode = 1'b0;
    in_x      = 8'd200;
    in_y      = 8'd200;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("mid_busy_before", {15'd0, busy}, 16'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_flags", {13'd0, busy, out_valid, in_ready}, 16'h0001);
    chk("mid_rst_add_op", {15'd0, add_op}, 16'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    run_op("mul_200x200", 1'b0, 8'd200, 8'd200, 8, 8'h9C, 8'h40, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
